ad4003_acq_ctrl: RTL and testbench

//  Sequencer for the AD4003 acquisition datapath. Sits between the stream/control registers and ad4003_acq.

---
 rtl/ad4003_acq_ctrl_if.sv | 39 +++
 rtl/ad4003_acq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ad4003_acq_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ad4003_acq_ctrl_if.sv
// Control/status bundle between the AD4003 acquisition sequencer (master) and its environment (slave).
// Defining ACQ_CTRL_TIMESTAMP_EN adds the sample_idx output to the bundle.
interface ad4003_acq_ctrl_if #(
    parameter int ADC_MODULES = 1
);
    logic                   enable;
    logic                   restart;
    logic [ADC_MODULES-1:0] adc_config_status;
    logic [1:0]             mode;
    logic                   adc_start_conv;
    logic                   word_sync_n;
    logic                   sample_valid;
    logic [2:0]             ctrl_state;
    logic [3:0]             retry_cnt;
    logic                   fault;
`ifdef ACQ_CTRL_TIMESTAMP_EN
    logic [31:0]            sample_idx;
`endif

    modport master (
        input  enable, restart, adc_config_status,
        output mode, adc_start_conv, word_sync_n, sample_valid, ctrl_state, retry_cnt,
`ifdef ACQ_CTRL_TIMESTAMP_EN
               fault, sample_idx
`else
               fault
`endif
    );

    modport slave (
        output enable, restart, adc_config_status,
        input  mode, adc_start_conv, word_sync_n, sample_valid, ctrl_state, retry_cnt,
`ifdef ACQ_CTRL_TIMESTAMP_EN
               fault, sample_idx
`else
               fault
`endif
    );
endinterface

// File: rtl/ad4003_acq_ctrl.sv
// AD4003 acquisition sequencer: configure, verify, then run periodic conversions.
// Optional feature macro ACQ_CTRL_TIMESTAMP_EN adds a per-sample index counter (sample_idx).
module ad4003_acq_ctrl #(
    parameter int ADC_MODULES  = 1,
    parameter int CONV_PERIOD  = 100,
    parameter int DATA_LATENCY = 80,
    parameter int CFG_WAIT     = 200,
    parameter int SYNC_DIV     = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk_100,
    input  logic              reset_n,
    ad4003_acq_ctrl_if.master bus
);
    localparam int PHASE_W = (CFG_WAIT > 0) ? $clog2(CFG_WAIT + 1) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CFG_WAIT);
    localparam logic [15:0]        PERIOD_LAST = 16'(CONV_PERIOD - 1);
    localparam logic [15:0]        VALID_AT    = 16'(DATA_LATENCY);
    localparam logic [7:0]         SYNC_LAST   = 8'(SYNC_DIV - 1);
    localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG_WR  = 3'd1,
        ST_CFG_RD  = 3'd2,
        ST_CFG_CHK = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'b00,
        MODE_CFG_WR  = 2'b01,
        MODE_CFG_RD  = 2'b10,
        MODE_ACQUIRE = 2'b11
    } mode_t;

    state_t               state;
    mode_t                mode_q;
    logic                 start_q;
    logic                 sync_n_q;
    logic                 valid_q;
    logic [3:0]           retry_q;
    logic                 fault_q;
    logic [PHASE_W-1:0]   phase_cnt;
    logic [15:0]          period_cnt;
    logic [7:0]           conv_cnt;

    logic [ADC_MODULES-1:0] status;
    logic                   cfg_ok;
    logic [15:0]            period_nxt;
    logic [7:0]             conv_nxt;

    assign status     = bus.adc_config_status;
    assign cfg_ok     = &status;
    assign period_nxt = period_cnt + 16'd1;
    assign conv_nxt   = (conv_cnt == SYNC_LAST) ? 8'd0 : conv_cnt + 8'd1;

`ifdef ACQ_CTRL_TIMESTAMP_EN
    logic [31:0] sample_idx;
    assign bus.sample_idx = sample_idx;
`endif

    // Outputs are registered one cycle ahead: every transition loads what the new state shows.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_IDLE;
            start_q    <= 1'b0;
            sync_n_q   <= 1'b1;
            valid_q    <= 1'b0;
            retry_q    <= '0;
            fault_q    <= 1'b0;
            phase_cnt  <= '0;
            period_cnt <= '0;
            conv_cnt   <= '0;
`ifdef ACQ_CTRL_TIMESTAMP_EN
            sample_idx <= '0;
`endif
        end else begin
            // NOTE: strobes default low here so each branch only raises what it needs; assignments are non-blocking so every branch sees pre-edge values.
            start_q  <= 1'b0;
            sync_n_q <= 1'b1;
            valid_q  <= 1'b0;
`ifdef ACQ_CTRL_TIMESTAMP_EN
            if (valid_q) sample_idx <= sample_idx + 32'd1;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state     <= ST_CFG_WR;
                        mode_q    <= MODE_CFG_WR;
                        start_q   <= 1'b1;
                        phase_cnt <= '0;
                        retry_q   <= 4'd1;
                    end
                end

                ST_CFG_WR: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        if (bus.enable) begin
                            state   <= ST_CFG_RD;
                            mode_q  <= MODE_CFG_RD;
                            start_q <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            mode_q <= MODE_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end

                ST_CFG_RD: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        if (bus.enable) begin
                            state <= ST_CFG_CHK;
                        end else begin
                            state  <= ST_IDLE;
                            mode_q <= MODE_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end

                ST_CFG_CHK: begin
                    if (!bus.enable) begin
                        state  <= ST_IDLE;
                        mode_q <= MODE_IDLE;
                    end else if (cfg_ok) begin
                        state      <= ST_RUN;
                        mode_q     <= MODE_ACQUIRE;
                        start_q    <= 1'b1;
                        sync_n_q   <= 1'b0;
                        period_cnt <= '0;
                        conv_cnt   <= (SYNC_LAST == 8'd0) ? 8'd0 : 8'd1;
`ifdef ACQ_CTRL_TIMESTAMP_EN
                        sample_idx <= '0;
`endif
                    end else if (retry_q < RETRY_MAX) begin
                        state     <= ST_CFG_WR;
                        mode_q    <= MODE_CFG_WR;
                        start_q   <= 1'b1;
                        phase_cnt <= '0;
                        retry_q   <= retry_q + 4'd1;
                    end else begin
                        state   <= ST_FAULT;
                        mode_q  <= MODE_IDLE;
                        fault_q <= 1'b1;
                    end
                end

                // Leaving only at the wrap keeps every started conversion whole.
                ST_RUN: begin
                    if (period_cnt == PERIOD_LAST) begin
                        period_cnt <= '0;
                        if (bus.enable) begin
                            start_q  <= 1'b1;
                            sync_n_q <= (conv_cnt != 8'd0);
                            conv_cnt <= conv_nxt;
                        end else begin
                            state  <= ST_IDLE;
                            mode_q <= MODE_IDLE;
                        end
                    end else begin
                        period_cnt <= period_nxt;
                        valid_q    <= (period_nxt == VALID_AT);
                    end
                end

                ST_FAULT: begin
                    if (bus.restart) begin
                        state   <= ST_IDLE;
                        mode_q  <= MODE_IDLE;
                        fault_q <= 1'b0;
                        retry_q <= '0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    mode_q <= MODE_IDLE;
                end
            endcase
        end
    end

    assign bus.mode           = mode_q;
    assign bus.adc_start_conv = start_q;
    assign bus.word_sync_n    = sync_n_q;
    assign bus.sample_valid   = valid_q;
    assign bus.ctrl_state     = state;
    assign bus.retry_cnt      = retry_q;
    assign bus.fault          = fault_q;
endmodule

// File: tb/tb_ad4003_acq_ctrl.sv
// Self-checking bench for ad4003_acq_ctrl: time-based reference model plus directed scenarios.
// Build with ACQ_CTRL_TIMESTAMP_EN defined to also check sample_idx.
module tb_ad4003_acq_ctrl;
    localparam int P  = 100;
    localparam int L  = 80;
    localparam int W  = 200;
    localparam int SD = 8;
    localparam int MR = 3;

    logic clk_100 = 1'b0;
    logic reset_n = 1'b0;

    ad4003_acq_ctrl_if #(.ADC_MODULES(1)) bus ();

    ad4003_acq_ctrl #(
        .ADC_MODULES (1),
        .CONV_PERIOD (P),
        .DATA_LATENCY(L),
        .CFG_WAIT    (W),
        .SYNC_DIV    (SD),
        .MAX_RETRY   (MR)
    ) dut (
        .clk_100(clk_100),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_100 = ~clk_100;

    int tests = 0;
    int fails = 0;
    int tb_cyc = 0;

    int   starts[$];
    logic syncs[$];
    int   valids[$];
    int   idxs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // Reference model: expected outputs as a function of cycles elapsed since the current segment began.
    typedef enum {M_IDLE, M_CFG, M_RUN, M_FAULT} seg_t;
    seg_t       seg   = M_IDLE;
    int         n     = 0;
    int         seg0  = 0;
    int         tries = 0;
    int         m_k;
    logic [1:0] e_mode   = 2'b00;
    logic       e_start  = 1'b0;
    logic       e_sync_n = 1'b1;
    logic       e_valid  = 1'b0;
    logic [2:0] e_state  = 3'd0;
    logic [3:0] e_retry  = 4'd0;
    logic       e_fault  = 1'b0;
    int         e_idx    = 0;

    initial begin : model
        forever begin
            @(posedge clk_100 or negedge reset_n);
            if (!reset_n) begin
                seg = M_IDLE; tries = 0; n = 0; seg0 = 0;
            end else begin
                n++;
                m_k = n - seg0;
                case (seg)
                    M_IDLE:
                        if (bus.enable) begin seg = M_CFG; seg0 = n; tries = 1; end
                    M_CFG:
                        if ((m_k == W + 1 || m_k == 2 * W + 2) && !bus.enable) seg = M_IDLE;
                        else if (m_k == 2 * W + 3) begin
                            if (!bus.enable) seg = M_IDLE;
                            else if (&bus.adc_config_status) begin seg = M_RUN; seg0 = n; end
                            else if (tries < MR) begin seg0 = n; tries++; end
                            else seg = M_FAULT;
                        end
                    M_RUN:
                        if (m_k > 0 && m_k % P == 0 && !bus.enable) seg = M_IDLE;
                    M_FAULT:
                        if (bus.restart) begin seg = M_IDLE; tries = 0; end
                endcase
            end
            m_k = n - seg0;
            e_mode = 2'b00; e_start = 1'b0; e_sync_n = 1'b1; e_valid = 1'b0;
            e_state = 3'd0; e_retry = 4'(tries); e_fault = 1'b0;
            case (seg)
                M_IDLE: ;
                M_CFG:
                    if (m_k <= W) begin
                        e_mode = 2'b01; e_state = 3'd1; e_start = (m_k == 0);
                    end else if (m_k <= 2 * W + 1) begin
                        e_mode = 2'b10; e_state = 3'd2; e_start = (m_k == W + 1);
                    end else begin
                        e_mode = 2'b10; e_state = 3'd3;
                    end
                M_RUN: begin
                    e_mode   = 2'b11;
                    e_state  = 3'd4;
                    e_start  = (m_k % P == 0);
                    e_sync_n = !(e_start && ((m_k / P) % SD == 0));
                    e_valid  = (m_k % P == L);
                    e_idx    = m_k / P;
                end
                M_FAULT: begin
                    e_state = 3'd5; e_fault = 1'b1;
                end
            endcase
        end
    end

    // Single compare process: every cycle, DUT against the model; also logs events for literal checks.
    initial begin : compare
        forever begin
            @(posedge clk_100);
            tb_cyc++;
            #3;
            check("outputs",
                  {bus.mode, bus.adc_start_conv, bus.word_sync_n, bus.sample_valid,
                   bus.ctrl_state, bus.retry_cnt, bus.fault},
                  {e_mode, e_start, e_sync_n, e_valid, e_state, e_retry, e_fault});
`ifdef ACQ_CTRL_TIMESTAMP_EN
            if (e_valid) check("sample_idx", bus.sample_idx, 64'(e_idx));
`endif
            if (bus.adc_start_conv) begin
                starts.push_back(tb_cyc);
                syncs.push_back(bus.word_sync_n);
            end
            if (bus.sample_valid) begin
                valids.push_back(tb_cyc);
`ifdef ACQ_CTRL_TIMESTAMP_EN
                idxs.push_back(int'(bus.sample_idx));
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", tb_cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    task automatic wait_to(input int target);
        while (tb_cyc < target) @(negedge clk_100);
    endtask

    task automatic clear_logs();
        starts.delete(); syncs.delete(); valids.delete(); idxs.delete();
    endtask

    initial begin : stimulus
        int c;
        int d;
        int ok_gaps;
        int sync_mask;
        int nv;
        bus.enable = 1'b0;
        bus.restart = 1'b0;
        bus.adc_config_status = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_100);
        // Reset packing: {mode,start,sync_n,valid,state,retry,fault} = 00,0,1,0,000,0000,0
        check("reset_outputs",
              {bus.mode, bus.adc_start_conv, bus.word_sync_n, bus.sample_valid,
               bus.ctrl_state, bus.retry_cnt, bus.fault}, 13'h200);
        reset_n = 1'b1;
        @(negedge clk_100);

        // Normal sequence, 20 run periods, enable dropped at period_cnt 10 of the 20th period.
        clear_logs();
        c = tb_cyc;
        bus.enable = 1'b1;
        wait_to(c + 2314);
        bus.enable = 1'b0;
        wait_to(c + 2430);
        check("start_count", starts.size(), 22);
        if (starts.size() == 22) begin
            check("cfg_wr_latency", starts[0] - c, 1);
            check("cfg_rd_offset", starts[1] - starts[0], 201);
            check("run_offset", starts[2] - starts[0], 403);
            check("cfg_pulses_unsynced", {syncs[0], syncs[1]}, 2'b11);
            ok_gaps = 0;
            sync_mask = 0;
            for (int j = 3; j < 22; j++) if (starts[j] - starts[j-1] == 100) ok_gaps++;
            for (int j = 2; j < 22; j++) if (!syncs[j]) sync_mask |= (1 << (j - 2));
            check("run_spacing", ok_gaps, 19);
            check("sync_positions", sync_mask, 32'h0001_0101);
        end
        check("valid_count", valids.size(), 20);
        if (valids.size() > 0 && starts.size() > 2)
            check("valid_latency", valids[0] - starts[2], 80);
`ifdef ACQ_CTRL_TIMESTAMP_EN
        if (idxs.size() >= 3) check("idx_first3", {idxs[0][7:0], idxs[1][7:0], idxs[2][7:0]}, 24'h000102);
        else check("idx_count", idxs.size(), 3);
`endif
        check("idle_after_drop", {bus.ctrl_state, bus.mode}, 5'b000_00);

        // Persistent config failure -> FAULT, then restart together with enable.
        clear_logs();
        c = tb_cyc;
        bus.adc_config_status = 1'b0;
        bus.enable = 1'b1;
        wait_to(c + 1220);
        check("fault_state", {bus.fault, bus.mode, bus.retry_cnt, bus.ctrl_state}, {1'b1, 2'b00, 4'd3, 3'd5});
        check("fault_pulses", starts.size(), 6);
        d = tb_cyc;
        bus.restart = 1'b1;
        bus.adc_config_status = 1'b1;
        @(negedge clk_100);
        bus.restart = 1'b0;
        check("restart_idle", {bus.ctrl_state, bus.fault, bus.retry_cnt}, {3'd0, 1'b0, 4'd0});
        @(negedge clk_100);
        check("restart_cfg_wr", {bus.adc_start_conv, bus.mode, bus.retry_cnt}, {1'b1, 2'b01, 4'd1});
        wait_to(d + 410);
        check("restart_run", {bus.mode, bus.ctrl_state}, {2'b11, 3'd4});
        bus.restart = 1'b1;
        @(negedge clk_100);
        bus.restart = 1'b0;
        bus.enable = 1'b0;
        wait_to(d + 520);
        check("restart_run_stop", {bus.mode, bus.ctrl_state}, {2'b00, 3'd0});

        // First check fails, second attempt passes.
        clear_logs();
        c = tb_cyc;
        bus.adc_config_status = 1'b0;
        bus.enable = 1'b1;
        wait_to(c + 450);
        bus.adc_config_status = 1'b1;
        wait_to(c + 820);
        check("retry_run", {bus.mode, bus.retry_cnt, bus.fault}, {2'b11, 4'd2, 1'b0});

        // Asynchronous reset one cycle before the sample strobe of the second period.
        wait_to(c + 986);
        nv = valids.size();
        check("valids_before_reset", nv, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.mode, bus.adc_start_conv, bus.word_sync_n, bus.sample_valid,
               bus.ctrl_state, bus.retry_cnt, bus.fault}, 13'h200);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk_100);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_100);
        check("no_valid_after_reset", valids.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
